// File: rtl/audio_seq_ctrl_if.sv
// Signal bundle between the audio sequencer and its ADC, processor and DAC neighbours.
interface audio_seq_ctrl_if;
   logic       enable;
   logic       clr_status;
   logic       adc_valid;
   logic [9:0] adc_data;
   logic [9:0] proc_data;
   logic       adc_start;
   logic       adc_channel;
   logic [9:0] proc_in;
   logic       proc_valid;
   logic [9:0] dac_data;
   logic       dac_start;
   logic [9:0] aux_sample;
   logic       busy;
   logic       err_timeout;
   logic [7:0] overrun_cnt;

   modport slave (
      input  enable, clr_status, adc_valid, adc_data, proc_data,
      output adc_start, adc_channel, proc_in, proc_valid, dac_data, dac_start,
             aux_sample, busy, err_timeout, overrun_cnt
   );

   modport master (
      output enable, clr_status, adc_valid, adc_data, proc_data,
      input  adc_start, adc_channel, proc_in, proc_valid, dac_data, dac_start,
             aux_sample, busy, err_timeout, overrun_cnt
   );
endinterface

// File: rtl/audio_seq_ctrl.sv
// Sample-rate scheduler for ADC -> processor -> DAC, with overrun and ADC-timeout status.
// Define SEQ_DUAL_CH_EN to alternate main/aux ADC channels on successive ticks.
module audio_seq_ctrl #(
   parameter logic [15:0] DIV      = 16'd4999,
   parameter int unsigned PROC_LAT = 2,
   parameter logic [11:0] TIMEOUT  = 12'd2047
) (
   input  logic             sysclk,
   input  logic             reset,
   audio_seq_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_ADC, S_PROC, S_DONE} state_t;

   localparam logic [11:0] PROC_LAST = 12'(PROC_LAT - 1);

   state_t      state_q, state_d;
   logic [15:0] tick_cnt_q, tick_cnt_d;
   logic [11:0] wait_q, wait_d;
   logic        valid_prev_q;
   logic        adc_start_q, adc_start_d;
   logic        proc_valid_q, proc_valid_d;
   logic        dac_start_q, dac_start_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic [7:0]  ovr_q, ovr_d;
   logic [9:0]  proc_in_q, proc_in_d;
   logic [9:0]  dac_q, dac_d;
   logic        tick, adc_edge, overrun, timeout, cur_main;

`ifdef SEQ_DUAL_CH_EN
   logic        chan_q, chan_d;
   logic        next_chan_q, next_chan_d;
   logic [9:0]  aux_q, aux_d;

   assign cur_main        = chan_q;
   assign bus.adc_channel = chan_q;
   assign bus.aux_sample  = aux_q;
`else
   assign cur_main        = 1'b1;
   assign bus.adc_channel = 1'b1;
   assign bus.aux_sample  = '0;
`endif

   assign tick     = bus.enable && (tick_cnt_q == DIV);
   assign adc_edge = bus.adc_valid && !valid_prev_q;
   assign overrun  = tick && (state_q != S_IDLE);

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      proc_in_d  = proc_in_q;
      dac_d      = dac_q;
      timeout    = 1'b0;
      tick_cnt_d = (!bus.enable || tick_cnt_q == DIV) ? 16'd0 : tick_cnt_q + 16'd1;
`ifdef SEQ_DUAL_CH_EN
      chan_d      = chan_q;
      next_chan_d = next_chan_q;
      aux_d       = aux_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d = S_START;
`ifdef SEQ_DUAL_CH_EN
               chan_d      = next_chan_q;
               next_chan_d = ~next_chan_q;
`endif
            end
         end
         S_START: begin
            wait_d  = '0;
            state_d = S_WAIT_ADC;
         end
         S_WAIT_ADC: begin
            // A valid edge on the abort cycle still wins over the timeout.
            if (adc_edge && cur_main) begin
               proc_in_d = bus.adc_data;
               wait_d    = '0;
               state_d   = S_PROC;
            end else if (adc_edge) begin
`ifdef SEQ_DUAL_CH_EN
               aux_d = bus.adc_data;
`endif
               state_d = S_IDLE;
            end else if (wait_q == TIMEOUT) begin
               timeout = 1'b1;
               state_d = S_IDLE;
            end else begin
               wait_d = wait_q + 12'd1;
            end
         end
         S_PROC: begin
            if (wait_q == PROC_LAST) begin
               dac_d   = bus.proc_data;
               state_d = S_DONE;
            end else begin
               wait_d = wait_q + 12'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A same-cycle event beats clr_status.
      if (overrun) begin
         ovr_d = bus.clr_status ? 8'd1 : ((ovr_q == 8'hFF) ? ovr_q : ovr_q + 8'd1);
      end else if (bus.clr_status) begin
         ovr_d = 8'd0;
      end else begin
         ovr_d = ovr_q;
      end
      err_d = timeout ? 1'b1 : (bus.clr_status ? 1'b0 : err_q);

      adc_start_d  = (state_d == S_START);
      proc_valid_d = (state_q == S_WAIT_ADC) && (state_d == S_PROC);
      dac_start_d  = (state_d == S_DONE);
      busy_d       = (state_d != S_IDLE);
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         tick_cnt_q   <= '0;
         wait_q       <= '0;
         valid_prev_q <= 1'b1;
         adc_start_q  <= 1'b0;
         proc_valid_q <= 1'b0;
         dac_start_q  <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         ovr_q        <= '0;
         proc_in_q    <= '0;
         dac_q        <= '0;
`ifdef SEQ_DUAL_CH_EN
         chan_q       <= 1'b1;
         next_chan_q  <= 1'b1;
         aux_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         wait_q       <= wait_d;
         valid_prev_q <= bus.adc_valid;
         adc_start_q  <= adc_start_d;
         proc_valid_q <= proc_valid_d;
         dac_start_q  <= dac_start_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         ovr_q        <= ovr_d;
         proc_in_q    <= proc_in_d;
         dac_q        <= dac_d;
`ifdef SEQ_DUAL_CH_EN
         chan_q       <= chan_d;
         next_chan_q  <= next_chan_d;
         aux_q        <= aux_d;
`endif
      end
   end

   assign bus.adc_start   = adc_start_q;
   assign bus.proc_valid  = proc_valid_q;
   assign bus.dac_start   = dac_start_q;
   assign bus.busy        = busy_q;
   assign bus.err_timeout = err_q;
   assign bus.overrun_cnt = ovr_q;
   assign bus.proc_in     = proc_in_q;
   assign bus.dac_data    = dac_q;
endmodule

// File: tb/tb_audio_seq_ctrl.sv
// Randomized scoreboard bench for audio_seq_ctrl against a timeline-level reference model.
module tb_audio_seq_ctrl;
   localparam int DIV = 99;
   localparam int PL  = 2;
   localparam int TO  = 200;
`ifdef SEQ_DUAL_CH_EN
   localparam bit DUAL = 1'b1;
`else
   localparam bit DUAL = 1'b0;
`endif

   typedef struct {
      int         cyc;
      bit         chk;
      logic       busy;
      logic       err;
      logic [7:0] ovr;
      logic [9:0] aux;
      logic [9:0] dac;
      logic [9:0] pin;
      logic       ch;
   } stat_t;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   logic sysclk = 1'b0;
   logic reset  = 1'b1;

   audio_seq_ctrl_if bus();

   audio_seq_ctrl #(.DIV(16'(DIV)), .PROC_LAT(PL), .TIMEOUT(12'(TO))) dut (
      .sysclk (sysclk),
      .reset  (reset),
      .bus    (bus)
   );

   // Processor model: inverts the sample.
   assign bus.proc_data = bus.proc_in ^ 10'h3FF;

   always #5 sysclk = ~sysclk;

   stat_t st_q[$];
   ev_t   start_q[$], pv_q[$], dac_q[$];
   int    checks = 0;
   int    errors = 0;

   // Reference model state: one outstanding sequence described by its absolute cycle times.
   int         cyc = 0, cnt = 0;
   bit         init = 1'b0;
   bit         s_act = 1'b0, s_edge = 1'b0, s_ch = 1'b1;
   int         s_t = 0, s_e = 0, s_end = 0;
   logic [9:0] s_data = '0;
   logic       m_err = 1'b0, m_ch = 1'b1, m_next = 1'b1;
   int         m_ovr = 0;
   logic [9:0] m_aux = '0, m_dac = '0, m_pin = '0;

   bit en_in = 1'b0, clr_pulse = 1'b0, rst_hold = 1'b1;
   bit no_edge = 1'b0, force_first = 1'b0, clr_on_ovr = 1'b0, clr_on_to = 1'b0, rst_after_pv = 1'b0;
   int d_lo = 1, d_hi = 85;

   task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, c, act, exp);
      end
   endtask

   task automatic step();
      logic busy_now, tick_now, ovr_now, to_now, clr, rst, v, n_err, n_ch;
      int n_ovr, d;
      logic [9:0] n_aux, n_dac, n_pin;
      stat_t s;
      busy_now = s_act && cyc > s_t && cyc < s_end;
      tick_now = en_in && cnt == DIV;
      to_now   = s_act && !s_edge && cyc == s_t + 2 + TO;
      clr = clr_pulse;
      if (clr_on_ovr && tick_now && busy_now) begin clr = 1'b1; clr_on_ovr = 1'b0; end
      if (clr_on_to && to_now) begin clr = 1'b1; clr_on_to = 1'b0; end
      rst = rst_hold;
      if (rst_after_pv && s_act && s_edge && s_ch && cyc == s_e + 2) begin rst = 1'b1; rst_after_pv = 1'b0; end
      v = s_act && s_edge && cyc == s_e;
      reset          = rst;
      bus.enable     = en_in;
      bus.clr_status = clr;
      bus.adc_valid  = v;
      bus.adc_data   = v ? s_data : 10'($urandom);

      s.cyc = cyc; s.chk = init; s.busy = busy_now; s.err = m_err; s.ovr = 8'(m_ovr);
      s.aux = m_aux; s.dac = m_dac; s.pin = m_pin; s.ch = m_ch;
      st_q.push_back(s);
      if (s_act && cyc == s_t + 1) start_q.push_back('{cyc, int'(s_ch)});
      if (s_act && s_edge && s_ch && cyc == s_e + 1) pv_q.push_back('{cyc, int'(s_data)});
      if (s_act && s_edge && s_ch && cyc == s_e + 1 + PL) dac_q.push_back('{cyc, int'(s_data ^ 10'h3FF)});

      n_aux = m_aux; n_dac = m_dac; n_pin = m_pin; n_ch = m_ch;
      if (v && s_ch) n_pin = s_data;
      if (v && !s_ch) n_aux = s_data;
      if (s_act && s_edge && s_ch && cyc == s_e + PL) n_dac = s_data ^ 10'h3FF;

      if (tick_now && !busy_now) begin
         s_act  = 1'b1;
         s_t    = cyc;
         s_ch   = DUAL ? m_next : 1'b1;
         m_next = DUAL ? !m_next : 1'b1;
         n_ch   = s_ch;
         if (force_first) begin
            d = 40; s_data = 10'h2A5; s_edge = 1'b1; force_first = 1'b0;
         end else begin
            d = int'($urandom_range(d_hi, d_lo)); s_data = 10'($urandom); s_edge = !no_edge;
         end
         s_e   = cyc + 1 + d;
         s_end = !s_edge ? cyc + 3 + TO : (s_ch ? s_e + 2 + PL : s_e + 1);
      end

      ovr_now = tick_now && busy_now;
      n_ovr = ovr_now ? (clr ? 1 : (m_ovr < 255 ? m_ovr + 1 : 255)) : (clr ? 0 : m_ovr);
      n_err = to_now ? 1'b1 : (clr ? 1'b0 : m_err);
      cnt   = (!en_in || cnt == DIV) ? 0 : cnt + 1;

      if (rst) begin
         s_act = 1'b0; cnt = 0; n_err = 1'b0; n_ovr = 0;
         n_aux = '0; n_dac = '0; n_pin = '0; n_ch = 1'b1; m_next = 1'b1; init = 1'b1;
      end
      m_err = n_err; m_ovr = n_ovr; m_aux = n_aux; m_dac = n_dac; m_pin = n_pin; m_ch = n_ch;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sysclk);
         #1;
         step();
      end
   endtask

   // Driver and reference model.
   initial begin
      bus.enable = 1'b0; bus.clr_status = 1'b0; bus.adc_valid = 1'b0; bus.adc_data = '0;
      run(3);
      rst_hold = 1'b0;
      en_in = 1'b1; force_first = 1'b1;
      run(160);
      run(1000);
      en_in = 1'b0; run(250);
      en_in = 1'b1; run(110);
      en_in = 1'b0; run(5);
      en_in = 1'b1; run(300);
      no_edge = 1'b1; clr_on_to = 1'b1;
      run(750);
      no_edge = 1'b0;
      run(120);
      clr_pulse = 1'b1; run(1);
      clr_pulse = 1'b0;
      d_lo = 120; d_hi = 190;
      run(260 * 200);
      clr_on_ovr = 1'b1;
      run(400);
      d_lo = 1; d_hi = 85; rst_after_pv = 1'b1;
      run(300);
      run(300);
      @(negedge sysclk);
      @(negedge sysclk);
      check("adc_start_pending", cyc, 32'(start_q.size()), 32'd0);
      check("proc_valid_pending", cyc, 32'(pv_q.size()), 32'd0);
      check("dac_start_pending", cyc, 32'(dac_q.size()), 32'd0);
      check("rst_mid_proc_done", cyc, 32'(rst_after_pv), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Monitor: compares status every cycle and pops pulse expectations when the DUT strobes.
   initial begin
      stat_t s;
      ev_t   e;
      forever begin
         @(negedge sysclk);
         if (st_q.size() != 0) begin
            s = st_q.pop_front();
            if (s.chk) begin
               check("busy", s.cyc, 32'(bus.busy), 32'(s.busy));
               check("err_timeout", s.cyc, 32'(bus.err_timeout), 32'(s.err));
               check("overrun_cnt", s.cyc, 32'(bus.overrun_cnt), 32'(s.ovr));
               check("aux_sample", s.cyc, 32'(bus.aux_sample), 32'(s.aux));
               check("dac_data", s.cyc, 32'(bus.dac_data), 32'(s.dac));
               check("proc_in", s.cyc, 32'(bus.proc_in), 32'(s.pin));
               check("adc_channel", s.cyc, 32'(bus.adc_channel), 32'(s.ch));

               if (bus.adc_start === 1'b1) begin
                  if (start_q.size() == 0) check("adc_start_spurious", s.cyc, 32'(bus.adc_start), 32'd0);
                  else begin
                     e = start_q.pop_front();
                     check("adc_start_time", s.cyc, 32'(s.cyc), 32'(e.cyc));
                     check("adc_start_channel", s.cyc, 32'(bus.adc_channel), 32'(e.val));
                  end
               end else if (start_q.size() != 0 && start_q[0].cyc <= s.cyc) begin
                  e = start_q.pop_front();
                  check("adc_start_missing", s.cyc, 32'(bus.adc_start), 32'd1);
               end

               if (bus.proc_valid === 1'b1) begin
                  if (pv_q.size() == 0) check("proc_valid_spurious", s.cyc, 32'(bus.proc_valid), 32'd0);
                  else begin
                     e = pv_q.pop_front();
                     check("proc_valid_time", s.cyc, 32'(s.cyc), 32'(e.cyc));
                     check("proc_valid_data", s.cyc, 32'(bus.proc_in), 32'(e.val));
                  end
               end else if (pv_q.size() != 0 && pv_q[0].cyc <= s.cyc) begin
                  e = pv_q.pop_front();
                  check("proc_valid_missing", s.cyc, 32'(bus.proc_valid), 32'd1);
               end

               if (bus.dac_start === 1'b1) begin
                  if (dac_q.size() == 0) check("dac_start_spurious", s.cyc, 32'(bus.dac_start), 32'd0);
                  else begin
                     e = dac_q.pop_front();
                     check("dac_start_time", s.cyc, 32'(s.cyc), 32'(e.cyc));
                     check("dac_start_data", s.cyc, 32'(bus.dac_data), 32'(e.val));
                  end
               end else if (dac_q.size() != 0 && dac_q[0].cyc <= s.cyc) begin
                  e = dac_q.pop_front();
                  check("dac_start_missing", s.cyc, 32'(bus.dac_start), 32'd1);
               end
            end
         end
      end
   end
endmodule

// File: doc/audio_seq_ctrl.md
# audio_seq_ctrl

Sample-rate scheduler for the ADC → processor → DAC audio path. It generates the sampling tick from `sysclk` and starts each `spi2adc` conversion. It hands each captured sample to the processor with a valid strobe, then fires the `spi2dac`/`pwm` load once the processor result has settled. It also detects dropped ticks (overrun) and ADC conversions that never complete (timeout), and reports both as status.

## Interface
- `DIV`, 4999: tick period is DIV+1 sysclk cycles (10 kHz at 50 MHz); 16-bit.
- `PROC_LAT`, 2: cycles from `proc_valid` to capture of `proc_data` (≥1).
- `TIMEOUT`, 2047: maximum cycles spent in WAIT_ADC before abort; 12-bit.
- `sysclk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: permits new conversions.
- `clr_status` in 1: clears `err_timeout` and `overrun_cnt`.
- `adc_valid` in 1: `data_valid` from `spi2adc`.
- `adc_data` in 10: `data_from_adc`.
- `proc_data` in 10: processor output.
- `adc_start` out 1: one-cycle conversion start.
- `adc_channel` out 1: channel to `spi2adc`.
- `proc_in` out 10: sample presented to processor.
- `proc_valid` out 1: one-cycle strobe to processor.
- `dac_data` out 10: held sample to `spi2dac`/`pwm`.
- `dac_start` out 1: one-cycle load strobe.
- `aux_sample` out 10: last aux-channel sample.
- `busy` out 1: state ≠ IDLE.
- `err_timeout` out 1: sticky timeout flag.
- `overrun_cnt` out 8: saturating count of dropped ticks.

## Operation
- Tick counter runs 0..DIV and wraps; `tick` is internal and high for one cycle when count = DIV.
  - The counter is held at 0 while `enable` = 0.
- FSM states:
  - IDLE: on `tick`, go to START.
  - START: `adc_start` = 1 for this cycle; clear the wait counter; go to WAIT_ADC.
  - WAIT_ADC: on a rising edge of `adc_valid` (current = 1, previous = 0), capture `adc_data`.
    - Main channel: load `proc_in`, go to PROC.
    - Aux channel: load `aux_sample`, go to IDLE.
    - If the wait counter reaches TIMEOUT: set `err_timeout`, go to IDLE with no DAC write.
  - PROC: `proc_valid` = 1 on the first cycle only. After PROC_LAT cycles, latch `proc_data` into `dac_data` and go to DONE.
  - DONE: `dac_start` = 1 for this cycle; go to IDLE.
- Main channel is 1 and aux channel is 0.
- `adc_channel` is registered. It updates only on the IDLE→START transition and is stable for the whole conversion.
- A `tick` while state ≠ IDLE is an overrun. The tick is dropped and `overrun_cnt` increments, saturating at 255.
  - A tick in the same cycle that DONE→IDLE occurs counts as an overrun.
- `clr_status` has lower priority than a same-cycle event:
  - Clear plus overrun gives `overrun_cnt` = 1.
  - Clear plus timeout leaves `err_timeout` = 1.
- `enable` falling mid-conversion does not abort; the current sequence completes.
- `reset` mid-sequence aborts immediately: no `dac_start`, no `proc_valid`.
- Previous `adc_valid` is reset to 1. A `valid` level that is already high when waiting begins is therefore not taken as a new edge.

## Timing
- Reset values:
  - state IDLE, tick counter 0, `adc_channel` 1.
  - Every other output 0: `adc_start`, `proc_valid`, `dac_start`, `busy`, `err_timeout`, `overrun_cnt`, `proc_in`, `dac_data`, `aux_sample`.
- `tick` in cycle T → `adc_start` in T+1 → `busy` high from T+1.
- `adc_valid` edge in cycle E → `proc_valid` and `proc_in` in E+1 → `dac_data` updated and `dac_start` high in E+1+PROC_LAT.
- `busy` falls in the cycle after `dac_start`.
- `dac_data` holds between loads.
- Timeout fires when WAIT_ADC has lasted TIMEOUT+1 cycles; state is IDLE on the next cycle.
- All outputs are registered. There are no combinational input→output paths.

## Configuration
- `SEQ_DUAL_CH_EN` defined:
  - `adc_channel` alternates 1, 0, 1, … on each accepted tick, starting at 1 after reset.
  - Channel-0 samples update `aux_sample` only; no processor or DAC activity.
  - DAC update rate is half the tick rate.
- `SEQ_DUAL_CH_EN` undefined:
  - `adc_channel` is constant 1 and every accepted tick runs the full path.
  - `aux_sample` is tied to 0.

## Test plan
- **Single conversion** (DIV = 99, PROC_LAT = 2, macro off; model returns `adc_data` = 10'h2A5 with a `valid` edge 40 cycles after `adc_start`; `proc_data` = `proc_in` ^ 10'h3FF):
  - `adc_start` 1 cycle after tick, `adc_channel` = 1.
  - `proc_in` = 2A5 with a single `proc_valid`.
  - `dac_data` = 15A, `dac_start` 3 cycles after the `valid` edge.
- **Rate**: 10 ticks with DIV = 99 → exactly 10 `adc_start` pulses spaced 100 cycles apart; `enable` = 0 → no `adc_start`, counter held at 0.
- **Timeout** (TIMEOUT = 50, ADC model never raises `valid`):
  - `err_timeout` = 1 after 51 WAIT_ADC cycles, no `dac_start`.
  - Next tick starts normally.
  - `clr_status` → `err_timeout` = 0.
- **Overrun**: ADC `valid` delayed 150 cycles with DIV = 99 → `overrun_cnt` increments once per sequence; after 300 sequences it reads 255 (saturated). `clr_status` in the same cycle as an overrun → `overrun_cnt` = 1.
- **Reset mid-PROC**: assert `reset` the cycle after `proc_valid` → no `dac_start`, all outputs at their reset values, `adc_channel` = 1.
- **Dual channel** (`SEQ_DUAL_CH_EN` on): four ticks → `adc_channel` sequence 1, 0, 1, 0.
  - Two `dac_start` pulses (channel 1 only).
  - `aux_sample` updates to the channel-0 values (e.g. 1C3 then 0F0).
